// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
// Contents:
//   state_t        FSM states IDLE / SHIFT / DONE
//   DIGITS         number of displayed BCD digits (A..D)
//   BCD_W          bits per BCD digit
//   SCRATCH_DIGITS digits held by the double-dabble scratch register
//   cnt_width()    iteration counter width for a given binary width
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGITS         = 4;
    localparam int BCD_W          = 4;
    localparam int SCRATCH_DIGITS = 5;
    localparam int SCRATCH_W      = SCRATCH_DIGITS * BCD_W;

    // Counter must hold the value bin_w itself, hence +1.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational double-dabble digit adjust (add 3 when >= 5)
// Ports:
//   digit    in  [3:0]  BCD scratch digit before the shift
//   adjusted out [3:0]  digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_W'(5)) begin
            adjusted = digit + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_conv.sv
// rtl/bin2bcd_conv.sv - sequential shift-and-add-3 binary to 4-digit BCD converter
// Parameters:
//   BIN_W  width of the binary input (4..16)
// Ports:
//   clk    in       rising-edge clock
//   rst    in       asynchronous active-high reset
//   start  in       request a conversion of bin (ignored while busy)
//   bin    in  [BIN_W-1:0] unsigned value to convert, captured on start
//   busy   out      conversion in progress, including the DONE cycle
//   done   out      one-cycle pulse when A..D/ovf carry a new result
//   A..D   out [3:0] thousands, hundreds, tens, units digits (registered)
//   ovf    out      last converted value exceeded 9999
// Build option:
//   BIN2BCD_OVF_SAT_EN  defined: results > 9999 saturate to 9999 with ovf=1;
//                       undefined: results wrap to value mod 10000, ovf=0.
module bin2bcd_conv
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(BIN_W);

    state_t                 state;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   adj;
    logic [BIN_W-1:0]       shreg;
    logic [CNT_W-1:0]       cnt;

    // Per-digit add-3 adjust of the scratch register ahead of each shift.
    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (scratch[g*BCD_W +: BCD_W]),
            .adjusted (adj[g*BCD_W +: BCD_W])
        );
    end

`ifdef BIN2BCD_OVF_SAT_EN
    // Any non-zero ten-thousands digit means the value is above 9999.
    logic over_range;
    assign over_range = (scratch[SCRATCH_W-1 -: BCD_W] != '0);
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            A       <= '0;
            B       <= '0;
            C       <= '0;
            D       <= '0;
`ifdef BIN2BCD_OVF_SAT_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // {scratch, shreg} shifts left one bit per cycle, MSB first.
                    // The bit leaving the top of the scratch is always 0 for
                    // BIN_W <= 16, so it is recirculated into the binary LSB.
                    scratch <= {adj[SCRATCH_W-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], adj[SCRATCH_W-1]};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef BIN2BCD_OVF_SAT_EN
                    if (over_range) begin
                        A   <= 4'd9;
                        B   <= 4'd9;
                        C   <= 4'd9;
                        D   <= 4'd9;
                        ovf <= 1'b1;
                    end else begin
                        A   <= scratch[3*BCD_W +: BCD_W];
                        B   <= scratch[2*BCD_W +: BCD_W];
                        C   <= scratch[1*BCD_W +: BCD_W];
                        D   <= scratch[0*BCD_W +: BCD_W];
                        ovf <= 1'b0;
                    end
`else
                    // Low four digits only: the value modulo 10000.
                    A <= scratch[3*BCD_W +: BCD_W];
                    B <= scratch[2*BCD_W +: BCD_W];
                    C <= scratch[1*BCD_W +: BCD_W];
                    D <= scratch[0*BCD_W +: BCD_W];
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
